// File: rtl/reg_display_scanner.sv
// reg_display_scanner: shift-add-3 BCD conversion of a selected register onto a 6-digit muxed seven-segment display.
// Define SIGNED_DISPLAY_EN to show the register as two's complement with a minus sign.
module reg_display_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] r_bus,
  input  logic [3:0]   reg_sel,
  output logic [6:0]   seg,
  output logic [5:0]   an,
  output logic         neg,
  output logic         busy
);
`ifdef SIGNED_DISPLAY_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
  state_t state;
  logic [15:0] sel_val, snap, shreg, mag;
  logic [3:0] snap_sel, bit_cnt, cur;
  logic [19:0] bcd, adj, digits;
  logic [31:0] dig_ext;
  logic [35:0] shifted;
  logic sign, sign_ld;
  logic [CW-1:0] rcnt;
  logic [2:0] idx;
  logic [7:0] blank;
  logic [6:0] seg_nxt;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  assign sel_val = r_bus[16*reg_sel +: 16];
  assign mag = (SIGNED_EN && sel_val[15]) ? -sel_val : sel_val;
  assign neg = sign;
  assign dig_ext = {12'd0, digits};
  assign shifted = {adj, shreg} << 1;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      snap <= '0;
      snap_sel <= '0;
      bcd <= '0;
      shreg <= '0;
      bit_cnt <= '0;
      digits <= '0;
      sign <= 1'b0;
      sign_ld <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel_val != snap || reg_sel != snap_sel) state <= LOAD;
        LOAD: begin
          snap <= sel_val;
          snap_sel <= reg_sel;
          shreg <= mag;
          bcd <= '0;
          bit_cnt <= '0;
          sign_ld <= SIGNED_EN && sel_val[15];
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, shreg} <= shifted;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= COMMIT;
        end
        COMMIT: begin
          digits <= bcd;
          sign <= sign_ld;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // blank[k]: digit k and every digit above it are zero
  always_comb begin
    blank = '0;
    blank[4] = digits[19:16] == 4'd0;
    for (int k = 3; k >= 1; k--) blank[k] = blank[k+1] && digits[4*k +: 4] == 4'd0;
    cur = dig_ext[4*idx +: 4];
    seg_nxt = idx == 3'd5 ? (sign ? 7'b0111111 : 7'b1111111) : blank[idx] ? 7'b1111111 : enc(cur);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      idx <= '0;
      an <= 6'h3F;
      seg <= 7'h7F;
    end else begin
      rcnt <= rcnt == CW'(REFRESH_DIV - 1) ? '0 : rcnt + CW'(1);
      if (rcnt == CW'(REFRESH_DIV - 1)) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
      an <= ~(6'd1 << idx);
      seg <= seg_nxt;
    end
  end
endmodule

// File: doc/reg_display_scanner.md
Name: reg_display_scanner

Overview:
- Downstream consumer of the datapath's r0..r15 register outputs.
- Selects one register via board switches and converts it sequentially from binary to decimal using a shift-add-3 FSM (one bit per cycle).
- Drives a 6-digit, active-low, time-multiplexed seven-segment display on the FPGA board.
- Holds the last converted value on the display while a new conversion runs, so the display does not flicker.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit before the scan advances (must be ≥2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- r_bus  input  256  concatenated registers; r_bus[16*i+15:16*i] = r_i (i = 0..15).
- reg_sel  input  4  index of the register to display.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  output  6  digit enables, active-low; an[0] = least-significant digit, an[5] = sign position.
- neg  output  1  displayed value is negative (only with the optional feature).
- busy  output  1  conversion in progress.

Behaviour:
- Clocking/reset: single clock domain; all state sampled on the rising edge of clk.
- Reset values when reset=1:
  - seg=7'h7F, an=6'h3F, neg=0, busy=0.
  - Snapshot register=16'h0000, snapshot select=4'h0.
  - Digit registers (d4..d0)=0, sign=0.
  - Scan index=0, refresh counter=0.
  - FSM in IDLE.
- Reset asserted mid-conversion aborts it immediately; no partial digits are committed.
- Selection: sel_val = r_bus[16*reg_sel +: 16], combinational.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE: if (sel_val != snapshot) or (reg_sel != snapshot select) -> LOAD; else stay.
  - LOAD (1 cycle): snapshot<=sel_val, snapshot select<=reg_sel. Compute magnitude (unsigned: the value itself). Clear the 20-bit BCD accumulator, load the 16-bit shift register, bit counter=0. busy<=1.
  - SHIFT (16 cycles): each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left by 1. Bit counter increments; after the 16th shift -> COMMIT.
  - COMMIT (1 cycle): d4..d0<=BCD nibbles, sign<=computed sign. busy<=0. -> IDLE.
- Latency: source change seen in IDLE at cycle N; new digits visible at cycle N+18 (1 LOAD + 16 SHIFT + 1 COMMIT).
- Source changes during LOAD/SHIFT/COMMIT are ignored until IDLE, then re-detected against the snapshot. Last value wins; no changes are queued.
- Unsigned range 0..65535; 5 BCD digits are always sufficient, no overflow.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, scan index advances 0->1->...->5->0.
  - an = ~(6'b1 << index), registered.
  - seg is registered in the same cycle as an (the two always change together).
- Digit encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Minus=0111111, blank=1111111.
- Leading-zero blanking:
  - Digit k (k=1..4) is blank when it and all higher digits are 0.
  - d0 is always shown.
  - Sign position (index 5) is blank, or minus when sign=1.
- First scan output after reset: one cycle after reset deasserts, an=6'b111110 and seg shows d0 (value 0 -> 1000000).

Optional Feature:
- Macro: SIGNED_DISPLAY_EN.
- Defined:
  - Value is two's complement.
  - LOAD takes magnitude = value[15] ? -value : value (16-bit; 16'h8000 -> 32768).
  - sign = value[15], and neg follows the committed sign.
  - Index 5 shows minus when sign=1.
- Undefined:
  - Unsigned interpretation.
  - sign and neg are held at 0.
  - Index 5 is always blank.

Test Plan:
- Reset, r_bus=0, REFRESH_DIV=4 -> busy stays 0; an steps 111110, 111101, ... every 4 cycles. Index 0 shows 1000000; indices 1–5 show 1111111.
- r3=16'd1234, reg_sel=3 -> busy high exactly 17 cycles (LOAD+SHIFT). After COMMIT, digits 0..3 show 4,3,2,1; index 4 blank. Display holds 0 until COMMIT.
- r0=16'hFFFF, unsigned build -> digits 65535, sign blank, neg=0.
- SIGNED_DISPLAY_EN, r0=16'hFFFF -> shows "-1" (index 5 minus, index 0 = 1, rest blank), neg=1. r0=16'h8000 -> 32768 with minus.
- Change reg_sel during SHIFT (r1=7, r2=42, switch 1->2 mid-conversion) -> first commit shows 7. The FSM then restarts from IDLE and commits 42 eighteen cycles later.
- Assert reset at SHIFT cycle 8 -> outputs return to reset values; after release, the value is reconverted from scratch and digits correct 18 cycles after IDLE detects the mismatch.
